// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC arbitration controller.
package plic_pkg;

   localparam int unsigned ID_W         = 8;
   localparam int unsigned PRIO_MAX_W   = 8;
   localparam int unsigned PRIO_VEC_MAX = 256 * PRIO_MAX_W;

   typedef enum logic {
      SCAN    = 1'b0,
      PUBLISH = 1'b1
   } scan_state_e;

   // Extracts the w-bit priority field of source i from a zero-extended packed vector.
   function automatic logic [PRIO_MAX_W-1:0] prio_at(
      input logic [PRIO_VEC_MAX-1:0] vec,
      input int unsigned             i,
      input int unsigned             w
   );
      logic [PRIO_VEC_MAX-1:0] sh;
      logic [PRIO_MAX_W-1:0]   mask;
      sh   = vec >> (i * w);
      mask = PRIO_MAX_W'((1 << w) - 1);
      return sh[PRIO_MAX_W-1:0] & mask;
   endfunction

endpackage

// File: rtl/plic_gateway.sv
// Single-source interrupt gateway: input sync, claim/complete inflight flag, ip gate.
module plic_gateway (
   input  logic clk,
   input  logic rst,
   input  logic irq,
   input  logic claim_hit,
   input  logic cmplt_hit,
   output logic gate
);

   logic src_q, src_d;
   logic inflight_q, inflight_d;
   logic gate_q, gate_d;

   always_comb begin
      src_d      = irq;
      inflight_d = inflight_q;
      // A claim in the same cycle as a completion keeps the source blocked.
      if (claim_hit) begin
         inflight_d = 1'b1;
      end else if (cmplt_hit) begin
         inflight_d = 1'b0;
      end
      gate_d = src_q & ~inflight_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_q      <= 1'b0;
         inflight_q <= 1'b0;
         gate_q     <= 1'b0;
      end else begin
         src_q      <= src_d;
         inflight_q <= inflight_d;
         gate_q     <= gate_d;
      end
   end

   assign gate = gate_q;

endmodule

// File: rtl/plic_arb_ctrl.sv
// PLIC sequencing/arbitration: per-source gateways plus a one-source-per-cycle
// priority scanner that publishes the winner and the external interrupt request.
module plic_arb_ctrl
   import plic_pkg::*;
#(
   parameter int unsigned EXT_IRQ_NUM = 31,
   parameter int unsigned PRIO_WIDTH  = 3
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [EXT_IRQ_NUM:0]                irq_src,
   input  logic [EXT_IRQ_NUM:0]                ip_r,
   input  logic [EXT_IRQ_NUM:0]                ie_r,
   input  logic [PRIO_WIDTH*(EXT_IRQ_NUM+1)-1:0] prio_r_1d,
   input  logic [PRIO_WIDTH-1:0]               threshold_r,
   input  logic [ID_W-1:0]                     claim_id,
   input  logic [ID_W-1:0]                     cmplt_id,
   input  logic                                cmplt_wr,
   output logic [EXT_IRQ_NUM:0]                plic_reg_gate,
   output logic [ID_W-1:0]                     final_id,
   output logic                                meip,
   output logic                                arb_valid
);

   scan_state_e           state_q, state_d;
   logic [ID_W-1:0]       idx_q, idx_d;
   logic [ID_W-1:0]       best_id_q, best_id_d;
   logic [PRIO_WIDTH-1:0] best_prio_q, best_prio_d;
   logic [ID_W-1:0]       final_id_q, final_id_d;
   logic                  meip_q, meip_d;
   logic                  arb_valid_q, arb_valid_d;

   logic [EXT_IRQ_NUM:0]  cand_vec;
   logic [EXT_IRQ_NUM:0]  cand_sh;
   logic                  cand;
   logic [PRIO_WIDTH-1:0] prio_cur;
   logic                  unused_src0;

   // Source 0 is reserved: no gateway, gate bit tied low.
   assign unused_src0      = irq_src[0];
   assign plic_reg_gate[0] = 1'b0;

   generate
      for (genvar gi = 1; gi <= EXT_IRQ_NUM; gi++) begin : g_gw
         plic_gateway u_gw (
            .clk       (clk),
            .rst       (rst),
            .irq       (irq_src[gi]),
            .claim_hit (claim_id == ID_W'(gi)),
            .cmplt_hit (cmplt_wr && (cmplt_id == ID_W'(gi))),
            .gate      (plic_reg_gate[gi])
         );
      end
   endgenerate

   assign cand_vec = ip_r & ie_r;
   assign cand_sh  = cand_vec >> idx_q;
   assign cand     = cand_sh[0];
   assign prio_cur = PRIO_WIDTH'(prio_at(PRIO_VEC_MAX'(prio_r_1d), 32'(idx_q), PRIO_WIDTH));

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      best_id_d   = best_id_q;
      best_prio_d = best_prio_q;
      final_id_d  = final_id_q;
      meip_d      = meip_q;
      arb_valid_d = 1'b0;

      case (state_q)
         SCAN: begin
            // Strict compare: ties keep the lower id and priority 0 never wins.
            if (cand && (prio_cur > best_prio_q)) begin
               best_id_d   = idx_q;
               best_prio_d = prio_cur;
            end
            if (idx_q == ID_W'(EXT_IRQ_NUM)) begin
               state_d = PUBLISH;
            end else begin
               idx_d = idx_q + 8'd1;
            end
         end
         PUBLISH: begin
            if (best_prio_q > threshold_r) begin
               final_id_d = best_id_q;
               meip_d     = 1'b1;
            end else begin
               final_id_d = '0;
               meip_d     = 1'b0;
            end
            arb_valid_d = 1'b1;
            best_id_d   = '0;
            best_prio_d = '0;
            idx_d       = 8'd1;
            state_d     = SCAN;
         end
         default: begin
            state_d = SCAN;
            idx_d   = 8'd1;
         end
      endcase

      // A claim retires the published id; rescan so a stale id is never republished.
      if (claim_id != '0) begin
         final_id_d  = '0;
         meip_d      = 1'b0;
         arb_valid_d = 1'b0;
         state_d     = SCAN;
         idx_d       = 8'd1;
         best_id_d   = '0;
         best_prio_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SCAN;
         idx_q       <= 8'd1;
         best_id_q   <= '0;
         best_prio_q <= '0;
         final_id_q  <= '0;
         meip_q      <= 1'b0;
         arb_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         best_id_q   <= best_id_d;
         best_prio_q <= best_prio_d;
         final_id_q  <= final_id_d;
         meip_q      <= meip_d;
         arb_valid_q <= arb_valid_d;
      end
   end

   assign final_id  = final_id_q;
   assign meip      = meip_q;
   assign arb_valid = arb_valid_q;

endmodule

// File: tb/tb_plic_arb_ctrl.sv
// Directed self-checking bench for plic_arb_ctrl at the default parameters.
module tb_plic_arb_ctrl;

   localparam int N  = 31;
   localparam int PW = 3;

   logic              clk;
   logic              rst;
   logic [N:0]        irq_src;
   logic [N:0]        ip_r;
   logic [N:0]        ie_r;
   logic [PW*(N+1)-1:0] prio_r_1d;
   logic [PW-1:0]     threshold_r;
   logic [7:0]        claim_id;
   logic [7:0]        cmplt_id;
   logic              cmplt_wr;
   logic [N:0]        plic_reg_gate;
   logic [7:0]        final_id;
   logic              meip;
   logic              arb_valid;

   int checks   = 0;
   int failures = 0;
   int cyc;

   plic_arb_ctrl #(.EXT_IRQ_NUM(N), .PRIO_WIDTH(PW)) dut (
      .clk           (clk),
      .rst           (rst),
      .irq_src       (irq_src),
      .ip_r          (ip_r),
      .ie_r          (ie_r),
      .prio_r_1d     (prio_r_1d),
      .threshold_r   (threshold_r),
      .claim_id      (claim_id),
      .cmplt_id      (cmplt_id),
      .cmplt_wr      (cmplt_wr),
      .plic_reg_gate (plic_reg_gate),
      .final_id      (final_id),
      .meip          (meip),
      .arb_valid     (arb_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns the number of cycles until the next arb_valid pulse, or -1 on timeout.
   task automatic wait_arb(output int c);
      c = -1;
      for (int n = 1; n <= 64; n++) begin
         @(posedge clk); #1;
         if (arb_valid) begin
            c = n;
            break;
         end
      end
      $display("publish after %0d cycles: final_id=%0d meip=%0d", c, final_id, meip);
   endtask

   task automatic set_prio(input int i, input int p);
      prio_r_1d[i*PW +: PW] = PW'(p);
   endtask

   task automatic clear_src();
      ip_r = '0; ie_r = '0; prio_r_1d = '0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         irq_src = $urandom; ip_r = $urandom; ie_r = $urandom;
         prio_r_1d = {$urandom, $urandom, $urandom};
         threshold_r = PW'($urandom); claim_id = 8'($urandom);
         cmplt_id = 8'($urandom); cmplt_wr = 1'($urandom);
         tick();
      end
      checks++; if (plic_reg_gate !== '0) begin failures++; $display("FAIL reset_gate got=%h exp=0", plic_reg_gate); end
      checks++; if (final_id !== 8'd0) begin failures++; $display("FAIL reset_final_id got=%0d exp=0", final_id); end
      checks++; if (meip !== 1'b0) begin failures++; $display("FAIL reset_meip got=%0d exp=0", meip); end
      checks++; if (arb_valid !== 1'b0) begin failures++; $display("FAIL reset_arb_valid got=%0d exp=0", arb_valid); end
      irq_src = '0; clear_src(); threshold_r = '0;
      claim_id = '0; cmplt_id = '0; cmplt_wr = 1'b0;
      rst = 1'b0;
      wait_arb(cyc);
      checks++; if (cyc != 32) begin failures++; $display("FAIL reset_first_publish got=%0d exp=32", cyc); end
      checks++; if (final_id !== 8'd0) begin failures++; $display("FAIL reset_empty_id got=%0d exp=0", final_id); end
   endtask

   task automatic test_single();
      ip_r[5] = 1'b1; ie_r[5] = 1'b1; set_prio(5, 3); threshold_r = 3'd1;
      wait_arb(cyc);
      checks++; if (cyc != 32) begin failures++; $display("FAIL period got=%0d exp=32", cyc); end
      checks++; if (final_id !== 8'd5) begin failures++; $display("FAIL single_id got=%0d exp=5", final_id); end
      checks++; if (meip !== 1'b1) begin failures++; $display("FAIL single_meip got=%0d exp=1", meip); end
      ie_r[5] = 1'b0;
      wait_arb(cyc);
      checks++; if (final_id !== 8'd0) begin failures++; $display("FAIL disabled_id got=%0d exp=0", final_id); end
      checks++; if (meip !== 1'b0) begin failures++; $display("FAIL disabled_meip got=%0d exp=0", meip); end
   endtask

   task automatic test_tie();
      clear_src(); threshold_r = 3'd0;
      ip_r[4] = 1'b1; ie_r[4] = 1'b1; set_prio(4, 2);
      ip_r[9] = 1'b1; ie_r[9] = 1'b1; set_prio(9, 2);
      wait_arb(cyc);
      checks++; if (final_id !== 8'd4) begin failures++; $display("FAIL tie_id got=%0d exp=4", final_id); end
      set_prio(9, 3);
      wait_arb(cyc);
      checks++; if (final_id !== 8'd9) begin failures++; $display("FAIL higher_prio_id got=%0d exp=9", final_id); end
   endtask

   task automatic test_threshold();
      clear_src(); threshold_r = 3'd2;
      ip_r[12] = 1'b1; ie_r[12] = 1'b1; set_prio(12, 2);
      wait_arb(cyc);
      checks++; if (final_id !== 8'd0) begin failures++; $display("FAIL thr_eq_id got=%0d exp=0", final_id); end
      checks++; if (meip !== 1'b0) begin failures++; $display("FAIL thr_eq_meip got=%0d exp=0", meip); end
      threshold_r = 3'd1;
      wait_arb(cyc);
      checks++; if (final_id !== 8'd12) begin failures++; $display("FAIL thr_below_id got=%0d exp=12", final_id); end
      checks++; if (meip !== 1'b1) begin failures++; $display("FAIL thr_below_meip got=%0d exp=1", meip); end
   endtask

   task automatic test_claim_complete();
      clear_src(); threshold_r = 3'd0;
      ip_r[7] = 1'b1; ie_r[7] = 1'b1; set_prio(7, 3);
      wait_arb(cyc);
      checks++; if (final_id !== 8'd7) begin failures++; $display("FAIL claim_pre_id got=%0d exp=7", final_id); end
      irq_src[7] = 1'b1; irq_src[3] = 1'b1;
      tick();
      checks++; if (plic_reg_gate[7] !== 1'b0) begin failures++; $display("FAIL gate_lat1 got=%0d exp=0", plic_reg_gate[7]); end
      tick();
      checks++; if (plic_reg_gate[7] !== 1'b1) begin failures++; $display("FAIL gate_lat2 got=%0d exp=1", plic_reg_gate[7]); end
      claim_id = 8'd7;
      tick();
      claim_id = 8'd0;
      checks++; if (plic_reg_gate[7] !== 1'b0) begin failures++; $display("FAIL claim_gate got=%0d exp=0", plic_reg_gate[7]); end
      checks++; if (plic_reg_gate[3] !== 1'b1) begin failures++; $display("FAIL claim_other_gate got=%0d exp=1", plic_reg_gate[3]); end
      checks++; if (final_id !== 8'd0) begin failures++; $display("FAIL claim_final_id got=%0d exp=0", final_id); end
      checks++; if (meip !== 1'b0) begin failures++; $display("FAIL claim_meip got=%0d exp=0", meip); end
      wait_arb(cyc);
      checks++; if (cyc != 32) begin failures++; $display("FAIL claim_restart got=%0d exp=32", cyc); end
      checks++; if (plic_reg_gate[7] !== 1'b0) begin failures++; $display("FAIL inflight_hold got=%0d exp=0", plic_reg_gate[7]); end
      cmplt_wr = 1'b1; cmplt_id = 8'd7;
      tick();
      cmplt_wr = 1'b0;
      tick();
      checks++; if (plic_reg_gate[7] !== 1'b1) begin failures++; $display("FAIL complete_gate got=%0d exp=1", plic_reg_gate[7]); end
      cmplt_wr = 1'b1; cmplt_id = 8'd3;
      tick();
      cmplt_wr = 1'b0;
      tick();
      checks++; if (plic_reg_gate[7] !== 1'b1 || plic_reg_gate[3] !== 1'b1) begin
         failures++; $display("FAIL stray_complete got=%0d%0d exp=11", plic_reg_gate[7], plic_reg_gate[3]);
      end
   endtask

   task automatic test_corners();
      // Claim and completion of the same id together: source stays blocked.
      claim_id = 8'd7; cmplt_wr = 1'b1; cmplt_id = 8'd7;
      tick();
      claim_id = 8'd0; cmplt_wr = 1'b0;
      checks++; if (plic_reg_gate[7] !== 1'b0) begin failures++; $display("FAIL same_cycle_gate got=%0d exp=0", plic_reg_gate[7]); end
      tick();
      checks++; if (plic_reg_gate[7] !== 1'b0) begin failures++; $display("FAIL same_cycle_hold got=%0d exp=0", plic_reg_gate[7]); end
      cmplt_wr = 1'b1; cmplt_id = 8'd7;
      tick();
      cmplt_wr = 1'b0;
      tick();
      checks++; if (plic_reg_gate[7] !== 1'b1) begin failures++; $display("FAIL recover_gate got=%0d exp=1", plic_reg_gate[7]); end

      // Claim landing exactly on the publish cycle.
      wait_arb(cyc);
      checks++; if (final_id !== 8'd7) begin failures++; $display("FAIL pub_claim_pre got=%0d exp=7", final_id); end
      repeat (31) @(posedge clk);
      #1; claim_id = 8'd7;
      tick();
      claim_id = 8'd0;
      checks++; if (arb_valid !== 1'b0) begin failures++; $display("FAIL pub_claim_valid got=%0d exp=0", arb_valid); end
      checks++; if (final_id !== 8'd0) begin failures++; $display("FAIL pub_claim_id got=%0d exp=0", final_id); end
      wait_arb(cyc);
      checks++; if (cyc != 32) begin failures++; $display("FAIL pub_claim_restart got=%0d exp=32", cyc); end
      cmplt_wr = 1'b1; cmplt_id = 8'd7;
      tick();
      cmplt_wr = 1'b0;

      // Reset mid-scan must drop the partial winner.
      wait_arb(cyc);
      clear_src(); threshold_r = 3'd0;
      ip_r[20] = 1'b1; ie_r[20] = 1'b1; set_prio(20, 5);
      wait_arb(cyc);
      checks++; if (final_id !== 8'd20) begin failures++; $display("FAIL mid_rst_pre got=%0d exp=20", final_id); end
      repeat (25) @(posedge clk);
      #1; rst = 1'b1; ip_r[20] = 1'b0;
      tick();
      rst = 1'b0;
      checks++; if (final_id !== 8'd0 || meip !== 1'b0 || arb_valid !== 1'b0 || plic_reg_gate !== '0) begin
         failures++; $display("FAIL mid_rst_outputs got=id%0d/m%0d/v%0d/g%h exp=0/0/0/0", final_id, meip, arb_valid, plic_reg_gate);
      end
      wait_arb(cyc);
      checks++; if (cyc != 32) begin failures++; $display("FAIL mid_rst_period got=%0d exp=32", cyc); end
      checks++; if (final_id !== 8'd0 || meip !== 1'b0) begin
         failures++; $display("FAIL mid_rst_discard got=id%0d/m%0d exp=0/0", final_id, meip);
      end
   endtask

   initial begin
      rst = 1'b1; irq_src = '0; clear_src(); threshold_r = '0;
      claim_id = '0; cmplt_id = '0; cmplt_wr = 1'b0;
      #1;
      test_reset();
      test_single();
      test_tie();
      test_threshold();
      test_claim_complete();
      test_corners();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
